// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Build option: define ID_EX_FWD_EN for EX/MEM and MEM/WB forwarding.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_ALU_ctrl,
  input  logic              id_alusrc,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [3:0]        ALU_ctrl,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [4:0]        shamt,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use_stall
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [3:0]        alu_ctrl;
    logic              alusrc;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic              load_hit;
  logic              raw_hit;

  // True when a nonzero destination collides with a source the ID instruction reads.
  function automatic logic reads(input logic [REG_AW-1:0] r);
    return (r != '0) &&
           ((r == id_rs_addr) ||
            (id_uses_rt && (r == id_rt_addr)));
  endfunction

  // Bundle the decode-stage fields for capture.
  always_comb begin
    d           = '0;
    d.valid     = id_valid;
    d.rs        = id_rs_addr;
    d.rt        = id_rt_addr;
    d.rd        = id_rd_addr;
    d.rs_data   = id_rs_data;
    d.rt_data   = id_rt_data;
    d.imm       = id_imm;
    d.shamt     = id_shamt;
    d.alu_ctrl  = id_ALU_ctrl;
    d.alusrc    = id_alusrc;
    d.reg_write = id_reg_write;
    d.mem_read  = id_mem_read;
    d.mem_write = id_mem_write;
  end

  // Pipeline register: reset > flush > hold > load-use bubble > capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (stall_in) begin
      q <= q;
    end else if (load_use_stall) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign load_hit = id_valid & q.valid & q.mem_read & reads(q.rd);

`ifdef ID_EX_FWD_EN
  logic ex_hit_rs;
  logic wb_hit_rs;
  logic ex_hit_rt;
  logic wb_hit_rt;

  assign ex_hit_rs = exmem_reg_write && (exmem_rd != '0) &&
                     (exmem_rd == q.rs);
  assign wb_hit_rs = memwb_reg_write && (memwb_rd != '0) &&
                     (memwb_rd == q.rs) && !ex_hit_rs;
  assign ex_hit_rt = exmem_reg_write && (exmem_rd != '0) &&
                     (exmem_rd == q.rt);
  assign wb_hit_rt = memwb_reg_write && (memwb_rd != '0) &&
                     (memwb_rd == q.rt) && !ex_hit_rt;

  // rs operand: youngest matching producer wins.
  always_comb begin
    rs_fwd = q.rs_data;
    unique case (1'b1)
      ex_hit_rs: rs_fwd = exmem_result;
      wb_hit_rs: rs_fwd = memwb_result;
      default:   rs_fwd = q.rs_data;
    endcase
  end

  // rt operand: youngest matching producer wins.
  always_comb begin
    rt_fwd = q.rt_data;
    unique case (1'b1)
      ex_hit_rt: rt_fwd = exmem_result;
      wb_hit_rt: rt_fwd = memwb_result;
      default:   rt_fwd = q.rt_data;
    endcase
  end

  assign raw_hit = 1'b0;
`else
  logic unused_fwd;

  // No bypass paths; every in-flight RAW hazard stalls instead.
  assign rs_fwd     = q.rs_data;
  assign rt_fwd     = q.rt_data;
  assign unused_fwd = ^{exmem_result, memwb_result};
  assign raw_hit    = id_valid &
                      ((q.valid & q.reg_write & reads(q.rd)) |
                       (exmem_reg_write & reads(exmem_rd)) |
                       (memwb_reg_write & reads(memwb_rd)));
`endif

  assign load_use_stall = load_hit | raw_hit;

  assign ALU_ctrl      = q.alu_ctrl;
  assign a             = rs_fwd;
  assign b             = q.alusrc ? q.imm : rt_fwd;
  assign shamt         = q.shamt;
  assign ex_valid      = q.valid;
  assign ex_rd         = q.rd;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_store_data = rt_fwd;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select logic that feeds the execute-stage ALU: captures decoded operands and controls, then drives the ALU's ALU_ctrl, a, b and shamt inputs.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, requests an IF/ID stall and inserts a bubble.
- Sits between the register-file/decode stage and the ALU.

Parameters:
DATA_W, 32, datapath width; ALU operands and results.
REG_AW, 5, register address width.

Ports:
clk  in  1  sole clock, rising edge.
rst_n  in  1  synchronous active-low reset.
id_valid  in  1  decode stage holds a real instruction.
id_rs_addr  in  REG_AW  source register rs.
id_rt_addr  in  REG_AW  source register rt.
id_rd_addr  in  REG_AW  destination register, already muxed rd/rt.
id_rs_data  in  DATA_W  register-file value for rs.
id_rt_data  in  DATA_W  register-file value for rt.
id_imm  in  DATA_W  extended immediate.
id_shamt  in  5  shift amount.
id_ALU_ctrl  in  4  ALU opcode: 0000 nop … 1001 sra.
id_alusrc  in  1  1 = b operand is immediate.
id_uses_rt  in  1  instruction reads rt.
id_reg_write  in  1  writes the register file.
id_mem_read  in  1  load.
id_mem_write  in  1  store.
stall_in  in  1  downstream hold; freeze ID/EX contents.
flush  in  1  squash the ID/EX contents, e.g. on a taken branch.
exmem_reg_write  in  1  EX/MEM writes a register; already valid-qualified.
exmem_rd  in  REG_AW  EX/MEM destination register.
exmem_result  in  DATA_W  EX/MEM ALU result.
memwb_reg_write  in  1  MEM/WB writes a register; already valid-qualified.
memwb_rd  in  REG_AW  MEM/WB destination register.
memwb_result  in  DATA_W  MEM/WB writeback value.
ALU_ctrl  out  4  to ALU.
a  out  DATA_W  to ALU.
b  out  DATA_W  to ALU.
shamt  out  5  to ALU.
ex_valid  out  1  EX holds a real instruction.
ex_rd  out  REG_AW  destination register.
ex_reg_write  out  1  register-write control.
ex_mem_read  out  1  load control.
ex_mem_write  out  1  store control.
ex_store_data  out  DATA_W  forwarded rt value for stores.
load_use_stall  out  1  to IF/ID: hold the decode stage this cycle.

Behaviour:
- Interface: one clock, clk; synchronous active-low reset, rst_n; all state updates on the rising edge of clk.
- Registered state: valid, rs/rt/rd addresses, rs/rt data, imm, shamt, ALU_ctrl, alusrc, reg_write, mem_read, mem_write.
- Reset (rst_n=0 at an edge): all registered fields cleared to 0, which gives ALU_ctrl=0000 (nop) and ex_valid=0. Reset overrides everything, including an operation in flight.
- Bubble: same contents as reset: valid=0, all controls 0, ALU_ctrl=0000, data fields 0.
- Update priority per edge: reset > flush (load bubble) > stall_in (hold all fields) > load_use_stall (load bubble) > capture id_* fields.
- When the stage captures, the captured valid equals id_valid.
- Latency: id_* inputs appear at the ALU one cycle later. Forwarding is combinational within the EX cycle.
- Forwarding for rs: if exmem_reg_write and exmem_rd!=0 and exmem_rd==ex_rs, use exmem_result. Else if the same test matches on memwb, use memwb_result. Else use the registered rs data.
- Forwarding for rt: same rule as rs.
- EX/MEM always beats MEM/WB when both match.
- Register 0 is never forwarded.
- a = forwarded rs.
- b = forwarded rt when alusrc=0, otherwise imm.
- ex_store_data = forwarded rt, regardless of alusrc.
- load_use_stall = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs_addr | (id_uses_rt & ex_rd==id_rt_addr)).
- load_use_stall is combinational and is asserted even when flush or stall_in is high; the priority rules above decide the register update.
- Simultaneous flush and stall_in: flush wins; a bubble is loaded.
- Stall held for N cycles: outputs are stable for N cycles, and forwarded values track the current exmem/memwb inputs.

Optional Feature:
ID_EX_FWD_EN
- Defined: forwarding exactly as described in Behaviour.
- Undefined: no forwarding muxes. a, b and ex_store_data use the registered data only.
- Undefined: load_use_stall widens to any RAW hazard: id_valid and an id source (rs, or rt when id_uses_rt) equals a nonzero destination of a writer in EX, EX/MEM or MEM/WB. The EX writer requires ex_valid & ex_reg_write; the EX/MEM and MEM/WB writers require their reg_write inputs.
- Undefined: the register file must write before it reads.

Test Plan:
- Reset: rst_n=0 with id_valid=1 and id_ALU_ctrl=0001 -> next cycle ALU_ctrl=0000, ex_valid=0, a=0, b=0, all controls 0.
- Capture: id add with rs_data=5, rt_data=7, alusrc=0 -> next cycle ALU_ctrl=0001, a=5, b=7. With alusrc=1 and imm=0xFFFFFFFC -> b=0xFFFFFFFC.
- Forward priority: ex_rs=3, exmem_rd=3 with result 0x11, memwb_rd=3 with result 0x22 -> a=0x11. Drop exmem_reg_write -> a=0x22. Set rs=0 with both stages matching -> a=registered data.
- Load-use: EX holds lw to r8, ID reads r8 as rs -> load_use_stall=1; next cycle ex_valid=0, ALU_ctrl=0000. With ID reading r8 as rt and id_uses_rt=0 -> load_use_stall=0.
- Stall/flush: stall_in=1 for 3 cycles -> outputs frozen. flush=1 together with stall_in=1 -> bubble loaded.
- Without ID_EX_FWD_EN: exmem_rd=4 with reg_write set, ID reads r4 -> load_use_stall=1, and a equals the registered value, not exmem_result.
